// File: rtl/aes_pkg.sv
// Shared AES types, FSM encoding and byte-layout helpers for the decrypt datapath.
package aes_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned STATE_W   = 128;
  localparam int unsigned NUM_BYTES = STATE_W / BYTE_W;

  typedef logic [STATE_W-1:0] aes_state_t;
  typedef logic [BYTE_W-1:0]  aes_byte_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } inv_sb_state_e;

  // Bit offset of the MSB of byte i; byte 0 is the most significant byte.
  function automatic int unsigned byte_msb(input int unsigned i);
    return STATE_W - 1 - BYTE_W * i;
  endfunction

endpackage

// File: rtl/invSBox.sv
// Combinational AES inverse S-box (single byte lookup).
module invSBox
  import aes_pkg::*;
(
  input  aes_byte_t i_byte,
  output aes_byte_t o_byte
);

  localparam aes_byte_t INV_TBL [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  assign o_byte = INV_TBL[i_byte];

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// Sequential AES InvSubBytes: substitutes LANES bytes per cycle of one 128-bit state.
module inv_sub_bytes_seq
  import aes_pkg::*;
#(
  parameter int unsigned LANES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_state,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_state,
  output logic               busy
);

  localparam int unsigned N     = NUM_BYTES / LANES;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  // Reject lane counts that do not evenly tile the 16-byte state.
  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
    $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  inv_sb_state_e    r_state;
  inv_sb_state_e    w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  aes_state_t       r_src;
  aes_state_t       r_result;
  aes_state_t       w_result_nxt;
  aes_byte_t        w_src_b    [NUM_BYTES];
  aes_byte_t        w_lane_in  [LANES];
  aes_byte_t        w_lane_out [LANES];

  // Split the captured source state into addressable bytes.
  always_comb begin
    for (int unsigned i = 0; i < NUM_BYTES; i++) begin
      w_src_b[i] = r_src[byte_msb(i) -: BYTE_W];
    end
  end

  // Lane k picks source byte cnt*LANES+k.
  always_comb begin
    for (int unsigned k = 0; k < LANES; k++) begin
      w_lane_in[k] = '0;
      for (int unsigned c = 0; c < N; c++) begin
        if (r_cnt == CNT_W'(c)) w_lane_in[k] = w_src_b[c * LANES + k];
      end
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    invSBox u_inv_sbox (
      .i_byte (w_lane_in[k]),
      .o_byte (w_lane_out[k])
    );
  end

  // Merge this cycle's lane results into their byte slots; other bytes hold.
  always_comb begin
    w_result_nxt = r_result;
    for (int unsigned i = 0; i < NUM_BYTES; i++) begin
      if (r_cnt == CNT_W'(i / LANES)) w_result_nxt[byte_msb(i) -: BYTE_W] = w_lane_out[i % LANES];
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (in_valid)          w_state_nxt = BUSY;
      BUSY:    if (r_cnt == CNT_LAST) w_state_nxt = DONE;
      DONE:    if (out_ready)         w_state_nxt = IDLE;
      default:                        w_state_nxt = IDLE;
    endcase
  end

  // Source capture, byte counter and result accumulation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_src    <= '0;
      r_result <= '0;
    end else if (r_state == IDLE && in_valid) begin
      r_src <= in_state;
      r_cnt <= '0;
    end else if (r_state == BUSY) begin
      r_result <= w_result_nxt;
      if (r_cnt != CNT_LAST) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign out_state = r_result;

endmodule
